// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: sends a 4-bit station code as a pulse-distance
// frame (start mark/space, four LSB-first bits, stop mark, idle gap)
// with the marks modulated by a square-wave carrier.
module ir_beacon_tx #(
  parameter int CARRIER_HALF = 1316,
  parameter int UNIT_LEN     = 52632,
  parameter int GAP_UNITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] code,
  output logic       ir_out,
  output logic       envelope,
  output logic       busy,
  output logic       done
);

  localparam int UW = (UNIT_LEN > 1) ? $clog2(UNIT_LEN) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_LEN - 1);
  localparam logic [CW-1:0] CARR_LAST = CW'(CARRIER_HALF - 1);
  localparam logic [3:0]    GAP_LAST  = 4'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    START_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  state_t          state;
  logic [UW-1:0]   unit_cnt;
  logic [3:0]      units_left;
  logic [CW-1:0]   carr_cnt;
  logic            carrier;
  logic [1:0]      bit_idx;
  logic [3:0]      code_q;

  // Frame sequencer: unit timing, state walk, carrier and registered outputs.
  // Transition branches assign carrier/ir_out after the free-running carrier
  // update so that the later assignment (phase restart) takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      units_left <= '0;
      carr_cnt   <= '0;
      carrier    <= 1'b0;
      bit_idx    <= '0;
      code_q     <= '0;
      ir_out     <= 1'b0;
      envelope   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          code_q     <= code;
          bit_idx    <= '0;
          state      <= START_MARK;
          units_left <= 4'd3;
          unit_cnt   <= '0;
          busy       <= 1'b1;
          envelope   <= 1'b1;
          carrier    <= 1'b1;
          carr_cnt   <= '0;
          ir_out     <= 1'b1;
        end
      end else begin
        if (carr_cnt == CARR_LAST) begin
          carr_cnt <= '0;
          carrier  <= ~carrier;
          ir_out   <= envelope & ~carrier;
        end else begin
          carr_cnt <= carr_cnt + CW'(1);
          ir_out   <= envelope & carrier;
        end

        if (unit_cnt != UNIT_LAST) begin
          unit_cnt <= unit_cnt + UW'(1);
        end else begin
          unit_cnt <= '0;
          if (units_left != 4'd0) begin
            units_left <= units_left - 4'd1;
          end else begin
            carrier  <= 1'b1;
            carr_cnt <= '0;
            case (state)
              START_MARK: begin
                state      <= START_SPACE;
                units_left <= 4'd1;
                envelope   <= 1'b0;
                ir_out     <= 1'b0;
              end
              START_SPACE: begin
                state      <= BIT_MARK;
                units_left <= 4'd0;
                envelope   <= 1'b1;
                ir_out     <= 1'b1;
              end
              BIT_MARK: begin
                state      <= BIT_SPACE;
                units_left <= code_q[bit_idx] ? 4'd2 : 4'd0;
                envelope   <= 1'b0;
                ir_out     <= 1'b0;
              end
              BIT_SPACE: begin
                state      <= (bit_idx == 2'd3) ? STOP_MARK : BIT_MARK;
                bit_idx    <= bit_idx + 2'd1;
                units_left <= 4'd0;
                envelope   <= 1'b1;
                ir_out     <= 1'b1;
              end
              STOP_MARK: begin
                state      <= GAP;
                units_left <= GAP_LAST;
                envelope   <= 1'b0;
                ir_out     <= 1'b0;
              end
              GAP: begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                envelope <= 1'b0;
                ir_out   <= 1'b0;
              end
              default: begin
                state    <= IDLE;
                busy     <= 1'b0;
                envelope <= 1'b0;
                ir_out   <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Testbench for ir_beacon_tx: directed and randomized frames compared
// cycle by cycle against a waveform model built from the frame format.
module tb_ir_beacon_tx;

  localparam int CH = 2;
  localparam int UL = 8;
  localparam int GU = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] code = 4'h0;
  logic       ir_out;
  logic       envelope;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail = 0;

  bit exp_env[$];
  bit exp_ir[$];

  ir_beacon_tx #(
    .CARRIER_HALF(CH),
    .UNIT_LEN(UL),
    .GAP_UNITS(GU)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .code(code),
    .ir_out(ir_out),
    .envelope(envelope),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Expected per-cycle envelope and ir_out for one frame, from the segment list.
  function automatic void build_frame(input logic [3:0] c);
    int units[$];
    bit marks[$];
    exp_env.delete();
    exp_ir.delete();
    units.push_back(4); marks.push_back(1'b1);
    units.push_back(2); marks.push_back(1'b0);
    for (int b = 0; b < 4; b++) begin
      units.push_back(1); marks.push_back(1'b1);
      units.push_back(c[b] ? 3 : 1); marks.push_back(1'b0);
    end
    units.push_back(1); marks.push_back(1'b1);
    units.push_back(GU); marks.push_back(1'b0);
    foreach (units[s]) begin
      for (int k = 0; k < units[s] * UL; k++) begin
        exp_env.push_back(marks[s]);
        exp_ir.push_back(marks[s] && (((k / CH) % 2) == 0));
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] c);
    start = s;
    code = c;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic exp_done);
    checkOutput({tag, "/idle_env"}, envelope, 1'b0);
    checkOutput({tag, "/idle_ir"}, ir_out, 1'b0);
    checkOutput({tag, "/idle_busy"}, busy, 1'b0);
    checkOutput({tag, "/idle_done"}, done, exp_done);
  endtask

  // Called one cycle after acceptance; ends in the IDLE cycle after the frame.
  task automatic runFrame(input logic [3:0] c, input string tag, input int poke_at,
                          input logic [3:0] poke_code, input logic hold);
    build_frame(c);
    foreach (exp_env[i]) begin
      checkOutput({tag, "/env"}, envelope, exp_env[i]);
      checkOutput({tag, "/ir"}, ir_out, exp_ir[i]);
      checkOutput({tag, "/busy"}, busy, 1'b1);
      checkOutput({tag, "/done"}, done, 1'b0);
      if (i == poke_at) applyStimulus(1'b1, poke_code);
      else if (hold) applyStimulus(1'b1, c);
      else applyStimulus(1'b0, 4'($urandom));
      tick();
    end
    checkIdle({tag, "/end"}, 1'b1);
  endtask

  initial begin
    logic [3:0] rc;
    int gap;

    $display("[TB] reset phase");
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'h0);
    tick();
    tick();
    checkIdle("reset", 1'b0);

    // Release reset together with a request: first edge accepts.
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h0);
    tick();
    runFrame(4'h0, "code0", -1, 4'h0, 1'b0);
    tick();
    checkIdle("code0_after", 1'b0);

    applyStimulus(1'b1, 4'hA);
    tick();
    runFrame(4'hA, "codeA", -1, 4'h0, 1'b0);
    tick();
    checkIdle("codeA_after", 1'b0);

    // Mid-frame start with a different code must not disturb the frame.
    applyStimulus(1'b1, 4'h5);
    tick();
    runFrame(4'h5, "poke", 50, 4'hF, 1'b0);
    tick();
    checkIdle("poke_after", 1'b0);

    // Asynchronous reset 40 cycles into a frame.
    applyStimulus(1'b1, 4'h3);
    tick();
    build_frame(4'h3);
    for (int i = 0; i < 40; i++) begin
      checkOutput("rstmid/env", envelope, exp_env[i]);
      checkOutput("rstmid/ir", ir_out, exp_ir[i]);
      checkOutput("rstmid/busy", busy, 1'b1);
      applyStimulus(1'b0, 4'h3);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("rstmid_async", 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkIdle("rstmid_quiet", 1'b0);
    end

    // start held: consecutive frames with one IDLE cycle between them.
    $display("[TB] back-to-back phase");
    applyStimulus(1'b1, 4'h0);
    tick();
    for (int f = 0; f < 3; f++) begin
      runFrame(4'h0, "b2b", -1, 4'h0, 1'b1);
      if (f < 2) tick();
    end
    applyStimulus(1'b0, 4'h0);
    tick();
    checkIdle("b2b_after", 1'b0);

    // Randomized frames with random idle spacing and mid-frame pokes.
    $display("[TB] random phase");
    for (int f = 0; f < 6; f++) begin
      rc = 4'($urandom);
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 4'($urandom));
        tick();
        checkIdle("rnd_gap", 1'b0);
      end
      applyStimulus(1'b1, rc);
      tick();
      runFrame(rc, "rnd", $urandom_range(100, 1), 4'($urandom), 1'b0);
    end
    applyStimulus(1'b0, 4'h0);
    tick();
    checkIdle("rnd_after", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
